// File: rtl/prime_sequencer.sv
// Trial-division sequencer: walks divisors d = 2, 3, ... against a latched candidate
// through an external divider, stopping at the first exact divisor or once d*d exceeds it.
module prime_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         btnC,
  input  logic         start,
  input  logic [W-1:0] A,
  output logic         busy,
  output logic         done,
  output logic         prime,
  output logic [W-1:0] factor,
  output logic [W-1:0] trials,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_done,
  input  logic [W-1:0] div_rem
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, FINISH} state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   factor_q, factor_d;
  logic [W-1:0]   trials_q, trials_d;
  logic           prime_q, prime_d;
  logic [2*W-1:0] d_wide, a_wide, d_sq;

  // Full-width square so the termination test cannot wrap near the top of the range.
  always_comb begin
    d_wide = {{W{1'b0}}, d_q};
    a_wide = {{W{1'b0}}, a_q};
    d_sq   = d_wide * d_wide;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    prime_d   = prime_q;
    factor_d  = factor_q;
    trials_d  = trials_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (a_q < TWO) begin
          prime_d  = 1'b0;
          factor_d = '0;
          trials_d = cnt_q;
          state_d  = FINISH;
        end else begin
          d_d     = TWO;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (d_sq > a_wide) begin
          prime_d  = 1'b1;
          factor_d = '0;
          trials_d = cnt_q;
          state_d  = FINISH;
        end else begin
          div_start = 1'b1;
          cnt_d     = cnt_q + ONE;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (div_done) begin
          rem_d   = div_rem;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          prime_d  = 1'b0;
          factor_d = d_q;
          trials_d = cnt_q;
          state_d  = FINISH;
        end else begin
          d_d     = d_q + ONE;
          state_d = ISSUE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results only change on the transition into FINISH, so they stay steady while busy.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state_q  <= IDLE;
      a_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      prime_q  <= 1'b0;
      factor_q <= '0;
      trials_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      prime_q  <= prime_d;
      factor_q <= factor_d;
      trials_q <= trials_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FINISH);
  assign prime  = prime_q;
  assign factor = factor_q;
  assign trials = trials_q;
  assign div_a  = a_q;
  assign div_b  = d_q;

endmodule

// File: tb/tb_prime_sequencer.sv
// Randomized bench for prime_sequencer: a random-latency divider model plus an
// arithmetic reference for primality, smallest factor, trial count and latency.
module tb_prime_sequencer;
  localparam int W      = 16;
  localparam int BUDGET = 10000;

  logic         clk = 1'b0;
  logic         btnC, start, div_done;
  logic [W-1:0] A, div_rem;
  logic         busy, done, prime, div_start;
  logic [W-1:0] factor, trials, div_a, div_b;

  prime_sequencer #(.W(W)) dut (
    .clk(clk), .btnC(btnC), .start(start), .A(A),
    .busy(busy), .done(done), .prime(prime), .factor(factor), .trials(trials),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Divider model state (only the main process touches it)
  bit           pend      = 1'b0;
  bit           stray_req = 1'b0;
  bit           prev_ds   = 1'b0;
  int           lat_cnt   = 0;
  int           lat_total = 0;
  int           n_issue   = 0;
  logic [W-1:0] cap_a, cap_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Trial division by plain arithmetic.
  task automatic model(input int a, output int p, output int f, output int t);
    p = 0; f = 0; t = 0;
    if (a < 2) return;
    for (int d = 2; d * d <= a; d++) begin
      t++;
      if (a % d == 0) begin
        f = d;
        return;
      end
    end
    p = 1;
  endtask

  // Advance one clock, sample 1 time unit later, and service the divider model.
  task automatic tick();
    @(posedge clk);
    #1;
    div_done = 1'b0;
    if (btnC) begin
      pend = 1'b0;
    end else if (stray_req) begin
      div_done  = 1'b1;
      div_rem   = '0;
      stray_req = 1'b0;
    end else if (pend) begin
      check_eq("div_a_hold", div_a, cap_a);
      check_eq("div_b_hold", div_b, cap_b);
      check_eq("div_start_in_wait", div_start, 0);
      lat_cnt--;
      if (lat_cnt == 0) begin
        div_done = 1'b1;
        div_rem  = cap_a % cap_b;
        pend     = 1'b0;
      end
    end else if (div_start) begin
      cap_a     = div_a;
      cap_b     = div_b;
      lat_cnt   = $urandom_range(1, 18);
      lat_total += lat_cnt;
      n_issue++;
      pend      = 1'b1;
    end
    check_eq("div_start_consec", prev_ds & div_start, 0);
    prev_ds = div_start;
  endtask

  task automatic run_candidate(input logic [W-1:0] a, input bit second_start);
    int ep, ef, et, n, lat0, iss0, exp_cycles;
    logic         p0;
    logic [W-1:0] f0, t0;
    bit arm, fire, release_start;
    model(int'(a), ep, ef, et);
    p0 = prime; f0 = factor; t0 = trials;
    lat0 = lat_total; iss0 = n_issue;
    arm = 1'b0; fire = 1'b0; release_start = 1'b0;
    start = 1'b1;
    A     = a;
    tick();
    start = 1'b0;
    A     = W'($urandom);
    n = 1;
    while (!done && n < BUDGET) begin
      check_eq("busy_during_run", busy, 1);
      check_eq("prime_stable", prime, p0);
      check_eq("factor_stable", factor, f0);
      check_eq("trials_stable", trials, t0);
      if (release_start) begin
        start = 1'b0;
        release_start = 1'b0;
      end
      if (arm) begin
        start = 1'b1;
        A     = 16'd2;
        arm   = 1'b0;
        release_start = 1'b1;
      end
      if (second_start && !fire && div_start) begin
        arm  = 1'b1;
        fire = 1'b1;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (n >= BUDGET) check_eq("done_timeout", 0, 1);
    exp_cycles = (a < 2) ? 2 : 2 + ep + 2 * et + (lat_total - lat0);
    $display("A=%0d prime=%0d factor=%0d trials=%0d cycles=%0d (ref %0d/%0d/%0d/%0d)",
             a, prime, factor, trials, n, ep, ef, et, exp_cycles);
    check_eq("done_cycle", n, exp_cycles);
    check_eq("prime", prime, ep);
    check_eq("factor", factor, ef);
    check_eq("trials", trials, et);
    check_eq("divisions_issued", n_issue - iss0, et);
    check_eq("busy_in_finish", busy, 1);
    tick();
    check_eq("done_one_pulse", done, 0);
    check_eq("idle_after_done", busy, 0);
  endtask

  initial begin
    int n;
    btnC = 1'b1; start = 1'b0; A = '0; div_done = 1'b0; div_rem = '0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_prime", prime, 0);
    check_eq("rst_factor", factor, 0);
    check_eq("rst_trials", trials, 0);
    check_eq("rst_div_start", div_start, 0);
    check_eq("rst_div_a", div_a, 0);
    check_eq("rst_div_b", div_b, 0);
    btnC = 1'b0;
    tick();

    run_candidate(16'd97, 1'b0);
    run_candidate(16'd91, 1'b0);
    run_candidate(16'd91, 1'b1);
    run_candidate(16'd4, 1'b0);
    run_candidate(16'd0, 1'b0);
    run_candidate(16'd1, 1'b0);
    run_candidate(16'd2, 1'b0);
    run_candidate(16'd3, 1'b0);
    run_candidate(16'd65521, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) run_candidate(W'($urandom_range(0, 300)), 1'b0);
      else            run_candidate(W'($urandom_range(0, 65535)), 1'b0);
    end

    // Abort mid-division, then feed the abandoned divider's completion.
    start = 1'b1;
    A     = 16'd65521;
    tick();
    start = 1'b0;
    n = 0;
    while (!div_start && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check_eq("issue_timeout", 0, 1);
    tick();
    #1;
    btnC = 1'b1;
    #1;
    $display("async reset during WAIT: busy=%0d div_a=%0d div_b=%0d", busy, div_a, div_b);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_div_start", div_start, 0);
    check_eq("arst_prime", prime, 0);
    check_eq("arst_factor", factor, 0);
    check_eq("arst_trials", trials, 0);
    check_eq("arst_div_a", div_a, 0);
    check_eq("arst_div_b", div_b, 0);
    tick();
    btnC = 1'b0;
    stray_req = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stray_busy", busy, 0);
      check_eq("stray_done", done, 0);
      check_eq("stray_div_start", div_start, 0);
    end
    run_candidate(16'd13, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
